seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
- Downstream display stage for the hex counter and logic-unit results on the Basys3 board.
- Captures a 16-bit value (four hex nibbles) plus per-digit decimal points, and time-multiplexes them onto the 4-digit common-anode seven-segment display.
- Includes anti-ghosting blanking, optional leading-zero suppression and tear-free updates at frame boundaries.
- Runs entirely on the 100 MHz board clock; no derived clocks.

Parameters:
- REFRESH_COUNT, 100_000: clock cycles per digit slot (1 ms at 100 MHz). Must be >= 2.
- BLANK_CYCLES, 1_000: cycles at the start of each slot during which all anodes are off. Must be < REFRESH_COUNT.

Ports:
- clk  input  1  100 MHz system clock.
- clr_n  input  1  asynchronous active-low reset.
- value  input  16  four hex digits; [3:0] is the rightmost digit (digit 0), [15:12] is digit 3.
- dp_in  input  4  decimal point per digit, 1 = lit; bit i maps to digit i.
- load  input  1  single-cycle strobe; samples value, dp_in and blank_lz into the pending register.
- blank_lz  input  1  1 = suppress leading zeros.
- an  output  4  anode enables, active-low; an[i] drives digit i.
- seg  output  7  cathodes, active-low, {g,f,e,d,c,b,a}.
- dp  output  1  decimal-point cathode, active-low.
- frame_done  output  1  one-cycle pulse when the display register takes a new frame.

Behaviour:
- Reset (clr_n low, asynchronous):
  - slot counter = 0, digit index = 0.
  - Pending and display registers (value, dp, blank_lz) = 0.
  - an = 4'b1111, seg = 7'b1111111, dp = 1, frame_done = 0.
- Slot counter:
  - Counts 0..REFRESH_COUNT-1, then wraps to 0.
  - Width is ceil(log2(REFRESH_COUNT)).
  - On wrap, digit index advances 0->1->2->3->0.
- Frame boundary: the cycle where the slot counter = REFRESH_COUNT-1 and the index = 3.
  - On that cycle the display register is loaded from the pending register.
  - If load is high on that same cycle, the display register takes value/dp_in/blank_lz directly (bypass), and the pending register also captures them.
  - frame_done is high in the following cycle only.
- load at any other cycle updates only the pending register. The shown digits never change mid-frame.
- Output timing: an, seg and dp are registered, so cycle t+1 outputs are decoded from cycle t counter/index/display state.
  - Slot counter < BLANK_CYCLES: an = 4'b1111.
  - Otherwise: an has only bit [index] = 0.
  - seg and dp follow the current index even while blanked.
- Hex decode, nibble -> seg:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Leading-zero blanking (display blank_lz = 1):
  - Digit i (i = 3,2,1) shows seg = 1111111 when nibble i and all higher nibbles are 0.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - dp is unaffected: dp = ~dp_in[i] even on a blanked digit.
- Reset mid-slot: all state returns to reset values immediately. Scanning resumes at digit 0, count 0, on the first clock after clr_n rises.
- load held high for several cycles: the pending register tracks the inputs each cycle. The last sampled values win at the boundary.

Test Plan:
- Reset/idle:
  - Setup: REFRESH_COUNT=8, BLANK_CYCLES=2.
  - Stimulus: assert clr_n low mid-run.
  - Required response: an=1111, seg=1111111, dp=1 immediately. After release, an=1110 is first seen on cycle 3 and held until cycle 8. Slot 1 shows an=1101 from cycle 11.
- Decode sweep:
  - Stimulus: load value=16'h0123, then 16'h4567, 16'h89AB, 16'hCDEF on successive frames.
  - Required response: each digit's seg matches the decode table. frame_done pulses once per frame.
- Tear-free update:
  - Stimulus: load 16'h1234 at frame start, then load 16'hABCD during digit-2's slot.
  - Required response: digits 2 and 3 still show 2 and 1 for that frame. The next frame shows D, C, B, A. frame_done is high exactly one cycle after the boundary.
- Simultaneous load at boundary:
  - Stimulus: load=1 with value=16'h00F0 on the boundary cycle.
  - Required response: the next frame shows 0,F,0,0 with no one-frame delay.
- Leading-zero blanking:
  - Stimulus: blank_lz=1 with value=16'h0000, then 16'h0050, then 16'h0100; dp_in=4'b1000.
  - 16'h0000: digits 3..1 blank, digit 0 shows "0".
  - 16'h0050: digits 3,2 blank; digit 1 = "5"; digit 0 = "0".
  - 16'h0100: digit 3 blank; digits 2..0 show 1,0,0.
  - dp=0 on digit 3 in all cases.
- Reset mid-slot:
  - Stimulus: pulse clr_n low while index=2, count=5.
  - Required response: outputs off immediately. The display register returns to 0. Scanning restarts at digit 0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: scans a 16-bit hex value onto a 4-digit common-anode display.
// Anti-ghost blanking per slot, leading-zero suppression, frame-synchronous updates.
module seg7_scan_driver #(
  parameter int REFRESH_COUNT = 100_000,
  parameter int BLANK_CYCLES  = 1_000
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int CW = $clog2(REFRESH_COUNT);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_COUNT - 1);
  localparam logic [CW-1:0] BLK  = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   pv_q, pv_d, dv_q, dv_d;
  logic [3:0]    pd_q, pd_d, dd_q, dd_d;
  logic          pl_q, pl_d, dl_q, dl_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          fd_q, fd_d;

  logic       wrap;
  logic       boundary;
  logic [3:0] nib;
  logic       lz_hit;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign wrap     = (cnt_q == LAST);
  assign boundary = wrap && (idx_q == 2'd3);

  // Pending next-state already holds the bypass, so the boundary copy covers load-on-boundary.
  always_comb begin
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = wrap ? idx_q + 2'd1 : idx_q;
    pv_d  = load ? value : pv_q;
    pd_d  = load ? dp_in : pd_q;
    pl_d  = load ? blank_lz : pl_q;
    dv_d  = dv_q;
    dd_d  = dd_q;
    dl_d  = dl_q;
    if (boundary) begin
      dv_d = pv_d;
      dd_d = pd_d;
      dl_d = pl_d;
    end
  end

  always_comb begin
    nib = dv_q[{idx_q, 2'b00} +: 4];
    unique case (idx_q)
      2'd3:    lz_hit = (dv_q[15:12] == 4'h0);
      2'd2:    lz_hit = (dv_q[15:8] == 8'h0);
      2'd1:    lz_hit = (dv_q[15:4] == 12'h0);
      default: lz_hit = 1'b0;
    endcase
  end

  always_comb begin
    an_d  = (cnt_q < BLK) ? 4'hF : ~(4'b0001 << idx_q);
    seg_d = (dl_q && lz_hit) ? 7'h7F : hex7(nib);
    dp_d  = ~dd_q[idx_q];
    fd_d  = boundary;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      pv_q  <= '0;
      pd_q  <= '0;
      pl_q  <= 1'b0;
      dv_q  <= '0;
      dd_q  <= '0;
      dl_q  <= 1'b0;
      an_q  <= 4'hF;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
      fd_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      pv_q  <= pv_d;
      pd_q  <= pd_d;
      pl_q  <= pl_d;
      dv_q  <= dv_d;
      dd_q  <= dd_d;
      dl_q  <= dl_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      fd_q  <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule
